mdu_seq_ctrl: RTL and testbench

Iterative multiply/divide sequencer for the MIPS datapath. It accepts MULT, MULTU, DIV and DIVU requests from the execute stage and runs a 32-step shift-add or restoring-divide loop. Results are written to the architectural HI/LO registers, which this block owns. While it runs it holds `busy` so the hazard unit stalls MFHI/MFLO. It replaces the single-cycle combinational product path for these four instructions.

---
 rtl/mdu_seq_ctrl_pkg.sv | 27 ++
 rtl/mdu_seq_ctrl_negate.sv | 13 +
 rtl/mdu_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op and state encodings, the iteration count and small op decoders.
package mdu_seq_ctrl_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_seq_ctrl_negate.sv
// Combinational conditional two's-complement negator.
// Passes the value through unchanged when en_i is low.
module mdu_negate #(
  parameter int W = 32
) (
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = en_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Signed ops run on magnitudes; signs are restored in a single FIX step.
module mdu_seq_ctrl
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d, a_raw_q, a_raw_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [WIDTH-1:0]   a_mag, b_mag, q_fix, r_fix;
  logic [2*WIDTH-1:0] p_fix;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic               in_signed, q_sign, p_sign;

  assign in_signed = op_is_signed(op_i);
  assign q_sign    = op_is_signed(op_q) & (sa_q ^ sb_q);
  assign p_sign    = q_sign;

  mdu_negate #(.W(WIDTH)) u_neg_a (.en_i(in_signed & a_i[WIDTH-1]), .val_i(a_i), .val_o(a_mag));
  mdu_negate #(.W(WIDTH)) u_neg_b (.en_i(in_signed & b_i[WIDTH-1]), .val_i(b_i), .val_o(b_mag));
  mdu_negate #(.W(WIDTH)) u_neg_q (.en_i(q_sign), .val_i(acc_q[WIDTH-1:0]), .val_o(q_fix));
  mdu_negate #(.W(WIDTH)) u_neg_r (.en_i(op_is_signed(op_q) & sa_q), .val_i(rem_q), .val_o(r_fix));
  mdu_negate #(.W(2*WIDTH)) u_neg_p (.en_i(p_sign), .val_i(acc_q), .val_o(p_fix));

  // Multiply keeps {partial product, remaining multiplier bits} in acc_q;
  // divide shifts dividend bits out of acc_q[WIDTH-1:0] and quotient bits in.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mag_b_q});
  assign div_sub   = div_shift[WIDTH-1:0] - mag_b_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    a_raw_d = a_raw_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i) begin
          state_d = ST_RUN;
          op_d    = op_i;
          sa_d    = in_signed & a_i[WIDTH-1];
          sb_d    = in_signed & b_i[WIDTH-1];
          mag_a_d = a_mag;
          mag_b_d = b_mag;
          a_raw_d = a_i;
          cnt_d   = '0;
          dz_d    = 1'b0;
          busy_d  = 1'b1;
          rem_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, (op_is_div(op_i) ? a_mag : b_mag)};
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_is_div(op_q)) begin
            rem_d              = div_ge ? div_sub : div_shift[WIDTH-1:0];
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
          if (op_is_div(op_q)) begin
            acc_d[WIDTH-1:0] = q_fix;
            rem_d            = r_fix;
          end else begin
            acc_d = p_fix;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!op_is_div(op_q)) begin
          hi_d = acc_q[2*WIDTH-1:WIDTH];
          lo_d = acc_q[WIDTH-1:0];
        end else if (mag_b_q == '0) begin
          hi_d = a_raw_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = rem_q;
          lo_d = acc_q[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      a_raw_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      a_raw_q <= a_raw_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign dz_o   = dz_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Bench for mdu_seq_ctrl: a transaction-level model (plain 64-bit arithmetic
// plus a cycle countdown) compared every cycle, and literal expectations per op.
module tb_mdu_seq_ctrl;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int checks = 0, failures = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mdu_seq_ctrl dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .abort_i(abort), .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .dz_o(dz), .hi_o(hi), .lo_o(lo)
  );

  // Expected architectural result of one op from plain arithmetic.
  function automatic void calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    longint      sx, sy, q, r;
    logic [63:0] p, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rdz = 1'b0;
    if (o == 2'b00) begin
      p = 64'(sx * sy);
      rh = p[63:32]; rl = p[31:0];
    end else if (o == 2'b01) begin
      p = {32'h0, x} * {32'h0, y};
      rh = p[63:32]; rl = p[31:0];
    end else if (y == 32'h0) begin
      rh = x; rl = 32'hFFFF_FFFF; rdz = 1'b1;
    end else if (o == 2'b10) begin
      q = sx / sy; r = sx % sy;
      qv = 64'(q); rv = 64'(r);
      rh = rv[31:0]; rl = qv[31:0];
    end else begin
      rh = x % y; rl = x / y;
    end
  endfunction

  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        p_dz = 1'b0;
  int          m_left = 0;

  // An accepted op commits 34 edges after its accept edge unless aborted first.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        if (start) begin
          calc(op, a, b, p_hi, p_lo, p_dz);
          m_busy = 1'b1; m_dz = 1'b0; m_left = 34;
        end
      end else if (m_left == 1) begin
        m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
        m_busy = 1'b0; m_done = 1'b1; m_left = 0;
      end else if (abort) begin
        m_busy = 1'b0; m_left = 0;
      end else begin
        m_left = m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if ({busy, done, dz, hi, lo} !== {m_busy, m_done, m_dz, m_hi, m_lo}) begin
        failures++;
        $display("FAIL cycle_model t=%0t busy/done/dz/hi/lo actual=%b/%b/%b/%h/%h required=%b/%b/%b/%h/%h",
                 $time, busy, done, dz, hi, lo, m_busy, m_done, m_dz, m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // mt_lat: edges after accept at which an MTHI/MTLO of DEADBEEF is also driven.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int mt_lat);
    int lat;
    bit seen;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'h0; b = 32'h0;
    lat = 0; seen = 1'b0;
    while (lat < 60 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        hi_we = (lat == mt_lat); lo_we = (lat == mt_lat); wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        lat++;
      end
    end
    hi_we = 1'b0; lo_we = 1'b0;
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'd34);
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
    chk({name, " dz"}, 32'(dz), 32'(edz));
    $display("op %s a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d", name, av, bv, hi, lo, dz, lat);
  endtask

  initial begin
    bit seen;
    #1 reset = 1'b1;
    #12 reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);

    run_op("MULT",  2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, -1);
    run_op("MULTU", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 10);
    run_op("DIV",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
    run_op("DIVU",  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 33);
    run_op("DIVU0", 2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, -1);
    run_op("DIVOVF", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, -1);

    @(negedge clk); hi_we = 1'b1; wdata = 32'h1357_9BDF;
    @(negedge clk); hi_we = 1'b0;
    chk("mthi idle", hi, 32'h1357_9BDF);

    // Abort mid-run, with an ignored start along the way.
    @(negedge clk); op = 2'b00; a = 32'd5; b = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int lat = 0; lat < 40; lat++) begin
      start = (lat == 9);
      if (lat == 9) begin op = 2'b11; a = 32'd99; b = 32'd3; end
      abort = (lat == 19);
      if (done) seen = 1'b1;
      if (lat == 21) chk("abort busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    chk("abort no_done", 32'(seen), 32'd0);
    chk("abort hi kept", hi, 32'h1357_9BDF);
    chk("abort lo kept", lo, 32'h8000_0000);
    $display("abort sequence hi=%h lo=%h busy=%b", hi, lo, busy);

    @(negedge clk); hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk); hi_we = 1'b0;
    chk("mthi after abort", hi, 32'hA5A5_A5A5);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk); op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_reset busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset hi", hi, 32'h0);
    chk("async reset lo", lo, 32'h0);
    $display("async reset t=%0t busy=%b hi=%h lo=%h", $time, busy, hi, lo);
    @(negedge clk); #2 reset = 1'b0;

    run_op("DIV_post_reset", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1);
    run_op("DIV_neg", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, -1);

    @(negedge clk);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
